uturn_motion_ctrl: RTL and testbench

- Owns the motor bridge and steering command while the robot performs a U-turn. Runs a three-point turn sequence on request and reports completion to the core.
- When idle, arbitrates in favour of the line-tracking controller by passing its motor and steer commands straight through.
- Sits between the core/tracking logic and the motor-driver and servo-PWM outputs.

---
 rtl/uturn_pkg.sv | 32 +++
 rtl/uturn_pwm_gen.sv | 34 +++
 rtl/uturn_motion_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_uturn_motion_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uturn_pkg.sv
// Shared types and codes for the U-turn motion controller.
// Optional build macro: UTURN_TIMEOUT_EN adds the FAULT state.
package uturn_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_BRAKE1,
      ST_FWD_LEFT,
      ST_BRAKE2,
      ST_REV_RIGHT,
      ST_BRAKE3,
      ST_SEEK,
      ST_DONE
`ifdef UTURN_TIMEOUT_EN
      , ST_FAULT
`endif
   } state_t;

   localparam logic [1:0] STEER_CENTRE = 2'b00;
   localparam logic [1:0] STEER_LEFT   = 2'b01;
   localparam logic [1:0] STEER_RIGHT  = 2'b10;

   localparam logic [1:0] MOT_FWD   = 2'b10;
   localparam logic [1:0] MOT_REV   = 2'b01;
   localparam logic [1:0] MOT_BRAKE = 2'b00;

   // The servo block has no meaning for 11; treat it as centre.
   function automatic logic [1:0] steer_map(input logic [1:0] code);
      return (code == 2'b11) ? STEER_CENTRE : code;
   endfunction

endpackage

// File: rtl/uturn_pwm_gen.sv
// Free-running PWM enable generator for the motor bridge.
// DUTY >= PERIOD gives a constant high, DUTY <= 0 a constant low.
module pwm_gen #(
   parameter int PERIOD = 2500,
   parameter int DUTY   = 1500
) (
   input  logic clk,
   input  logic rst,
   output logic pwm_on
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] cnt;

   // Counter wraps at PERIOD-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (cnt == CW'(PERIOD - 1))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   if (DUTY >= PERIOD) begin : g_always_on
      assign pwm_on = 1'b1;
   end else if (DUTY <= 0) begin : g_never_on
      assign pwm_on = 1'b0;
   end else begin : g_compare
      assign pwm_on = (cnt < CW'(DUTY));
   end

endmodule

// File: rtl/uturn_motion_ctrl.sv
// Three-point U-turn sequencer; passes the line-tracking commands
// through while idle. Optional build macro UTURN_TIMEOUT_EN bounds the
// SEEK phase and adds a FAULT state.
//
// state        | meaning
// IDLE         | tracking controller drives the outputs
// BRAKE1       | stop before turning
// FWD_LEFT     | forward arc, full left
// BRAKE2       | stop, wheels still left
// REV_RIGHT    | reverse arc, full right
// BRAKE3       | stop, wheels still right
// SEEK         | creep forward-left until the line is found
// DONE         | one-clk completion pulse
// FAULT        | line not found in time; waits for a new request
module uturn_motion_ctrl
   import uturn_pkg::*;
#(
   parameter int BRAKE_MS    = 100,
   parameter int FWD_MS      = 600,
   parameter int REV_MS      = 500,
   parameter int SEEK_MIN_MS = 200,
   parameter int SEEK_MAX_MS = 3000,
   parameter int PWM_PERIOD  = 2500,
   parameter int DUTY        = 1500,
   parameter int TIMER_W     = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ms_tick,
   input  logic [3:0] ir,
   input  logic       en_uturn,
   input  logic [1:0] trk_motor_ctrl,
   input  logic [1:0] trk_motor_en,
   input  logic [1:0] trk_steer,
   output logic [1:0] motor_ctrl,
   output logic [1:0] motor_en,
   output logic [1:0] steer,
   output logic       uturn_finished,
   output logic       busy,
   output logic       fault
);

   if (SEEK_MAX_MS <= SEEK_MIN_MS) begin : g_bad_seek_cfg
      $error("SEEK_MAX_MS must exceed SEEK_MIN_MS");
   end

   state_t             state;
   state_t             state_next;
   logic [TIMER_W-1:0] timer;
   logic [3:0]         ir_m;
   logic [3:0]         ir_s;
   logic               en_q;
   logic               start;
   logic               pwm_on;
   logic               line_seen;
   logic               seek_ok;

   logic [1:0]         ctrl_d;
   logic [1:0]         en_d;
   logic [1:0]         steer_d;
   logic               fin_d;
   logic               busy_d;
`ifdef UTURN_TIMEOUT_EN
   logic               fault_d;
`endif

   logic               unused_ir;
   assign unused_ir = &{1'b0, ir_s[0], ir_s[3]};

   pwm_gen #(
      .PERIOD (PWM_PERIOD),
      .DUTY   (DUTY)
   ) u_pwm (
      .clk    (clk),
      .rst    (rst),
      .pwm_on (pwm_on)
   );

   // IR sensors are asynchronous; two-flop synchroniser.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_m <= '0;
         ir_s <= '0;
      end else begin
         ir_m <= ir;
         ir_s <= ir_m;
      end
   end

   // Rising-edge detect on the request level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         en_q <= 1'b0;
      else
         en_q <= en_uturn;
   end

   assign start     = en_uturn & ~en_q;
   assign line_seen = ir_s[1] | ir_s[2];
   assign seek_ok   = (timer >= TIMER_W'(SEEK_MIN_MS)) && line_seen;

   // Phase timer: cleared on state entry, saturates so an unbounded SEEK
   // never wraps back below the minimum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         timer <= '0;
      else if (state_next != state)
         timer <= '0;
      else if (ms_tick && (timer != '1))
         timer <= timer + 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:
            if (start) state_next = ST_BRAKE1;
         ST_BRAKE1:
            if (ms_tick && (timer == TIMER_W'(BRAKE_MS - 1))) state_next = ST_FWD_LEFT;
         ST_FWD_LEFT:
            if (ms_tick && (timer == TIMER_W'(FWD_MS - 1))) state_next = ST_BRAKE2;
         ST_BRAKE2:
            if (ms_tick && (timer == TIMER_W'(BRAKE_MS - 1))) state_next = ST_REV_RIGHT;
         ST_REV_RIGHT:
            if (ms_tick && (timer == TIMER_W'(REV_MS - 1))) state_next = ST_BRAKE3;
         ST_BRAKE3:
            if (ms_tick && (timer == TIMER_W'(BRAKE_MS - 1))) state_next = ST_SEEK;
         ST_SEEK: begin
            // Detection is checked first so it wins over a coincident timeout.
            if (seek_ok)
               state_next = ST_DONE;
`ifdef UTURN_TIMEOUT_EN
            else if (ms_tick && (timer == TIMER_W'(SEEK_MAX_MS - 1)))
               state_next = ST_FAULT;
`endif
         end
         ST_DONE:
            state_next = ST_IDLE;
`ifdef UTURN_TIMEOUT_EN
         ST_FAULT:
            if (start) state_next = ST_BRAKE1;
`endif
         default:
            state_next = ST_IDLE;
      endcase
   end

   // Output decode; default is the brake pattern with the sequencer owning the bridge.
   always_comb begin
      ctrl_d  = MOT_BRAKE;
      en_d    = 2'b11;
      steer_d = STEER_CENTRE;
      fin_d   = 1'b0;
      busy_d  = 1'b1;
`ifdef UTURN_TIMEOUT_EN
      fault_d = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            ctrl_d  = trk_motor_ctrl;
            en_d    = trk_motor_en;
            steer_d = steer_map(trk_steer);
            busy_d  = 1'b0;
         end
         ST_FWD_LEFT: begin
            ctrl_d  = MOT_FWD;
            en_d    = {2{pwm_on}};
            steer_d = STEER_LEFT;
         end
         ST_BRAKE2:
            steer_d = STEER_LEFT;
         ST_REV_RIGHT: begin
            ctrl_d  = MOT_REV;
            en_d    = {2{pwm_on}};
            steer_d = STEER_RIGHT;
         end
         ST_BRAKE3:
            steer_d = STEER_RIGHT;
         ST_SEEK: begin
            ctrl_d  = MOT_FWD;
            en_d    = {2{pwm_on}};
            steer_d = STEER_LEFT;
         end
         ST_DONE:
            fin_d = 1'b1;
`ifdef UTURN_TIMEOUT_EN
         ST_FAULT:
            fault_d = 1'b1;
`endif
         default: begin
            ctrl_d  = MOT_BRAKE;
            en_d    = 2'b11;
            steer_d = STEER_CENTRE;
         end
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         motor_ctrl     <= MOT_BRAKE;
         motor_en       <= 2'b00;
         steer          <= STEER_CENTRE;
         uturn_finished <= 1'b0;
         busy           <= 1'b0;
      end else begin
         motor_ctrl     <= ctrl_d;
         motor_en       <= en_d;
         steer          <= steer_d;
         uturn_finished <= fin_d;
         busy           <= busy_d;
      end
   end

`ifdef UTURN_TIMEOUT_EN
   // Fault flag register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fault <= 1'b0;
      else
         fault <= fault_d;
   end
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_uturn_motion_ctrl.sv
// Directed bench for uturn_motion_ctrl with short phase parameters.
`timescale 1ns/1ps
module tb_uturn_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ms_tick = 1'b0;
   logic [3:0] ir = 4'b0000;
   logic       en_uturn = 1'b0;
   logic [1:0] trk_motor_ctrl = 2'b00;
   logic [1:0] trk_motor_en = 2'b00;
   logic [1:0] trk_steer = 2'b00;
   logic [1:0] motor_ctrl;
   logic [1:0] motor_en;
   logic [1:0] steer;
   logic       uturn_finished;
   logic       busy;
   logic       fault;

   int errors = 0;
   int checks = 0;
   int edge_cnt = 0;
   int tick_div = 0;

   uturn_motion_ctrl #(
      .BRAKE_MS    (2),
      .FWD_MS      (3),
      .REV_MS      (3),
      .SEEK_MIN_MS (1),
      .SEEK_MAX_MS (5),
      .PWM_PERIOD  (4),
      .DUTY        (2),
      .TIMER_W     (12)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ms_tick        (ms_tick),
      .ir             (ir),
      .en_uturn       (en_uturn),
      .trk_motor_ctrl (trk_motor_ctrl),
      .trk_motor_en   (trk_motor_en),
      .trk_steer      (trk_steer),
      .motor_ctrl     (motor_ctrl),
      .motor_en       (motor_en),
      .steer          (steer),
      .uturn_finished (uturn_finished),
      .busy           (busy),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   // One-clk ms strobe every 10 clocks.
   always @(negedge clk) begin
      tick_div = (tick_div == 9) ? 0 : tick_div + 1;
      ms_tick  = (tick_div == 9);
   end

   // Clock edges since reset release; the PWM counter starts from 0 with it.
   always @(posedge clk or negedge rst) begin
      if (!rst)
         edge_cnt <= 0;
      else
         edge_cnt <= edge_cnt + 1;
   end

   // Output after edge k was captured with PWM count (k-1) mod 4; on for counts 0,1.
   function automatic logic pwm_exp();
      return (((edge_cnt - 1) % 4) < 2);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for a {motor_ctrl, steer} signature, then counts how long it holds
   // while checking motor_en and busy each cycle. Optionally pokes ir or
   // pulses en_uturn at a given sample index.
   task automatic phase(input string tag, input logic [1:0] c, input logic [1:0] s,
                        input bit motion, input int poke_at, input logic [3:0] ir_val,
                        input int pulse_at, output int len);
      int guard;
      int bad;
      guard = 0;
      bad   = 0;
      len   = 0;
      while (({motor_ctrl, steer} !== {c, s}) && (guard < 100)) begin
         @(negedge clk);
         guard++;
      end
      while (({motor_ctrl, steer} === {c, s}) && (len < 400)) begin
         if (len == poke_at) ir = ir_val;
         if (len == pulse_at) en_uturn = 1'b1;
         if ((pulse_at >= 0) && (len == pulse_at + 1)) en_uturn = 1'b0;
         if (motion) begin
            if (motor_en !== {2{pwm_exp()}}) bad++;
         end else if (motor_en !== 2'b11) begin
            bad++;
         end
         if (busy !== 1'b1) bad++;
         len++;
         @(negedge clk);
      end
      check({tag, "_en_busy"}, bad, 0);
   endtask

   task automatic pulse_start();
      en_uturn = 1'b1;
      @(negedge clk);
      en_uturn = 1'b0;
   endtask

   // BRAKE1 through BRAKE3 with length checks; returns at the first SEEK sample.
   task automatic seq_front(input string tag, input int rev_pulse_at);
      int len;
      phase({tag, "_brake1"}, 2'b00, 2'b00, 1'b0, -1, 4'b0000, -1, len);
      check({tag, "_brake1_len"}, (len >= 11 && len <= 20), 1);
      phase({tag, "_fwd"}, 2'b10, 2'b01, 1'b1, -1, 4'b0000, -1, len);
      check({tag, "_fwd_len"}, len, 30);
      phase({tag, "_brake2"}, 2'b00, 2'b01, 1'b0, -1, 4'b0000, -1, len);
      check({tag, "_brake2_len"}, len, 20);
      phase({tag, "_rev"}, 2'b01, 2'b10, 1'b1, -1, 4'b0000, rev_pulse_at, len);
      check({tag, "_rev_len"}, len, 30);
      phase({tag, "_brake3"}, 2'b00, 2'b10, 1'b0, -1, 4'b0000, -1, len);
      check({tag, "_brake3_len"}, len, 20);
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"}, {uturn_finished, busy, motor_ctrl, motor_en, steer},
            {1'b1, 1'b1, 2'b00, 2'b11, 2'b00});
      @(negedge clk);
      check({tag, "_after_done"}, {uturn_finished, busy, motor_ctrl}, {1'b0, 1'b0, 2'b11});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int len;
      int busy_cnt;
      rst = 1'b1;
      #1 rst = 1'b0;
      trk_motor_ctrl = 2'b10;
      trk_motor_en   = 2'b11;
      trk_steer      = 2'b01;
      repeat (3) @(negedge clk);
      check("reset_outs", {motor_ctrl, motor_en, steer, uturn_finished, busy, fault}, 0);
      rst = 1'b1;

      // Idle passthrough, including steer code 11 mapping to centre.
      trk_motor_ctrl = 2'b10; trk_motor_en = 2'b11; trk_steer = 2'b11;
      @(negedge clk);
      check("idle_pass1", {motor_ctrl, motor_en, steer, busy}, {2'b10, 2'b11, 2'b00, 1'b0});
      trk_motor_ctrl = 2'b01; trk_motor_en = 2'b01; trk_steer = 2'b10;
      @(negedge clk);
      check("idle_pass2", {motor_ctrl, motor_en, steer, busy}, {2'b01, 2'b01, 2'b10, 1'b0});
      trk_motor_ctrl = 2'b11; trk_motor_en = 2'b00; trk_steer = 2'b00;
      repeat (2) @(negedge clk);

      // Full sequence, line on ir[2] at SEEK timer=2.
      pulse_start();
      seq_front("s1", -1);
      phase("s1_seek", 2'b10, 2'b01, 1'b1, 20, 4'b0100, -1, len);
      check("s1_seek_len", len, 24);
      check_done("s1");
      ir = 4'b0000;
      repeat (5) @(negedge clk);

      // en held high: line present at SEEK entry is held off until timer=1,
      // and no retrigger after DONE.
      en_uturn = 1'b1;
      seq_front("s2", -1);
      phase("s2_seek", 2'b10, 2'b01, 1'b1, 0, 4'b0010, -1, len);
      check("s2_seek_len", len, 11);
      check_done("s2");
      busy_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_cnt++;
      end
      check("s2_no_retrigger", busy_cnt, 0);
      en_uturn = 1'b0;
      ir = 4'b0000;
      repeat (5) @(negedge clk);

      // Second request during REV_RIGHT is ignored.
      pulse_start();
      seq_front("s3", 10);
      phase("s3_seek", 2'b10, 2'b01, 1'b1, 0, 4'b0100, -1, len);
      check("s3_seek_len", len, 11);
      check_done("s3");
      ir = 4'b0000;
      repeat (5) @(negedge clk);

      // No line in SEEK.
      pulse_start();
      seq_front("s4", -1);
`ifdef UTURN_TIMEOUT_EN
      phase("s4_seek", 2'b10, 2'b01, 1'b1, -1, 4'b0000, -1, len);
      check("s4_seek_len", len, 50);
      check("s4_fault", {fault, busy, motor_ctrl, motor_en, steer, uturn_finished},
            {1'b1, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0});
      pulse_start();
      @(negedge clk);
      check("s4_restart", {fault, busy, motor_ctrl, motor_en, steer},
            {1'b0, 1'b1, 2'b00, 2'b11, 2'b00});
`else
      phase("s4_seek", 2'b10, 2'b01, 1'b1, -1, 4'b0000, -1, len);
      check("s4_seek_persist", len, 400);
      check("s4_no_fault", {fault, busy}, {1'b0, 1'b1});
`endif
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of FWD_LEFT.
      pulse_start();
      phase("s5_brake1", 2'b00, 2'b00, 1'b0, -1, 4'b0000, -1, len);
      repeat (5) @(negedge clk);
      check("s5_in_fwd", {motor_ctrl, steer, busy}, {2'b10, 2'b01, 1'b1});
      #2 rst = 1'b0;
      #1;
      check("s5_async_rst", {motor_ctrl, motor_en, steer, uturn_finished, busy, fault}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("s5_idle_after", {motor_ctrl, motor_en, steer, busy}, {2'b11, 2'b00, 2'b00, 1'b0});
      busy_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_cnt++;
      end
      check("s5_stays_idle", busy_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
